// File: rtl/mfp_gpio_access_arbiter.sv
// AHB-Lite master sharing the GPIO slave between two req/ack requesters, round-robin.
// Each transaction is IDLE->ADDR->DATA->ACK; all outputs are registered.
module mfp_gpio_access_arbiter #(
  parameter logic [31:0] BASE_ADDR = 32'h1F800000
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        req0,
  input  logic        req1,
  input  logic        write0,
  input  logic        write1,
  input  logic [3:0]  ionum0,
  input  logic [3:0]  ionum1,
  input  logic [31:0] wdata0,
  input  logic [31:0] wdata1,
  output logic        ack0,
  output logic        ack1,
  output logic [31:0] rdata,
  output logic        err,
  output logic [31:0] HADDR,
  output logic [1:0]  HTRANS,
  output logic        HWRITE,
  output logic [2:0]  HSIZE,
  output logic [2:0]  HBURST,
  output logic        HSEL,
  output logic [31:0] HWDATA,
  input  logic [31:0] HRDATA,
  input  logic        HREADY,
  input  logic        HRESP
);

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_ACK} state_e;

  localparam logic [1:0] TR_IDLE   = 2'b00;
  localparam logic [1:0] TR_NONSEQ = 2'b10;

  state_e      state_q, state_d;
  logic        last_grant_q, last_grant_d;
  logic        gnt_q, gnt_d;
  logic [31:0] wd_q, wd_d;
  logic [31:0] haddr_q, haddr_d;
  logic [1:0]  htrans_q, htrans_d;
  logic        hsel_q, hsel_d;
  logic        hwrite_q, hwrite_d;
  logic [31:0] hwdata_q, hwdata_d;
  logic        ack0_q, ack0_d;
  logic        ack1_q, ack1_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic        pick;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    gnt_d        = gnt_q;
    wd_d         = wd_q;
    haddr_d      = haddr_q;
    htrans_d     = htrans_q;
    hsel_d       = hsel_q;
    hwrite_d     = hwrite_q;
    hwdata_d     = hwdata_q;
    ack0_d       = 1'b0;
    ack1_d       = 1'b0;
    rdata_d      = rdata_q;
    err_d        = err_q;
    pick         = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (req0 || req1) begin
          // Tie goes to whoever was not served last.
          pick         = (req0 && req1) ? ~last_grant_q : req1;
          last_grant_d = pick;
          gnt_d        = pick;
          wd_d         = pick ? wdata1 : wdata0;
          hwrite_d     = pick ? write1 : write0;
          haddr_d      = BASE_ADDR | {26'd0, (pick ? ionum1 : ionum0), 2'b00};
          htrans_d     = TR_NONSEQ;
          hsel_d       = 1'b1;
          state_d      = S_ADDR;
        end
      end
      S_ADDR: begin
        if (HREADY) begin
          htrans_d = TR_IDLE;
          hsel_d   = 1'b0;
          hwdata_d = wd_q;
          state_d  = S_DATA;
        end
      end
      S_DATA: begin
        if (HREADY) begin
          if (!hwrite_q) rdata_d = HRDATA;
          err_d   = HRESP;
          ack0_d  = ~gnt_q;
          ack1_d  = gnt_q;
          state_d = S_ACK;
        end
      end
      S_ACK: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q      <= S_IDLE;
      last_grant_q <= 1'b1;
      gnt_q        <= 1'b0;
      wd_q         <= 32'd0;
      haddr_q      <= 32'd0;
      htrans_q     <= TR_IDLE;
      hsel_q       <= 1'b0;
      hwrite_q     <= 1'b0;
      hwdata_q     <= 32'd0;
      ack0_q       <= 1'b0;
      ack1_q       <= 1'b0;
      rdata_q      <= 32'd0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      gnt_q        <= gnt_d;
      wd_q         <= wd_d;
      haddr_q      <= haddr_d;
      htrans_q     <= htrans_d;
      hsel_q       <= hsel_d;
      hwrite_q     <= hwrite_d;
      hwdata_q     <= hwdata_d;
      ack0_q       <= ack0_d;
      ack1_q       <= ack1_d;
      rdata_q      <= rdata_d;
      err_q        <= err_d;
    end
  end

  assign HADDR  = haddr_q;
  assign HTRANS = htrans_q;
  assign HWRITE = hwrite_q;
  assign HSIZE  = 3'b010;
  assign HBURST = 3'b000;
  assign HSEL   = hsel_q;
  assign HWDATA = hwdata_q;
  assign ack0   = ack0_q;
  assign ack1   = ack1_q;
  assign rdata  = rdata_q;
  assign err    = err_q;

endmodule

// File: tb/tb_mfp_gpio_access_arbiter.sv
// Bench for mfp_gpio_access_arbiter: directed table, round-robin, mid-transfer reset
// and randomized traffic against a transaction-level requester/arbiter model.
module tb_mfp_gpio_access_arbiter;

  localparam logic [31:0] BASE = 32'h1F800000;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic        req0, req1, write0, write1;
  logic [3:0]  ionum0, ionum1;
  logic [31:0] wdata0, wdata1;
  logic        ack0, ack1;
  logic [31:0] rdata;
  logic        err;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE, HBURST;
  logic        HSEL;
  logic [31:0] HWDATA, HRDATA;
  logic        HREADY, HRESP;

  mfp_gpio_access_arbiter dut (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .req0(req0), .req1(req1), .write0(write0), .write1(write1),
    .ionum0(ionum0), .ionum1(ionum1), .wdata0(wdata0), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1), .rdata(rdata), .err(err),
    .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST),
    .HSEL(HSEL), .HWDATA(HWDATA), .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP)
  );

  always #5 HCLK = ~HCLK;

  // Requester-side model state
  bit          pend [2];
  logic        wr   [2];
  logic [3:0]  ion  [2];
  logic [31:0] wd   [2];
  int          lg;
  logic [31:0] rdata_m;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    int          id;
    logic        wr;
    logic [3:0]  ion;
    logic [31:0] wd;
    logic [31:0] hrd;
    logic        hresp;
    int          sa;
    int          sd;
    logic [31:0] exp_haddr;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vt [6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive_reqs();
    req0 = pend[0]; write0 = wr[0]; ionum0 = ion[0]; wdata0 = wd[0];
    req1 = pend[1]; write1 = wr[1]; ionum1 = ion[1]; wdata1 = wd[1];
  endtask

  task automatic new_tx(input int i);
    pend[i] = 1'b1;
    wr[i]   = 1'($urandom);
    ion[i]  = 4'($urandom);
    wd[i]   = $urandom;
  endtask

  // Entered at the negedge of a cycle in which the DUT is idle; the next posedge grants g.
  task automatic run_one(input int g, input int sa, input int sd,
                         input logic [31:0] hrd, input logic hresp_i,
                         input logic [31:0] e_haddr, input logic [31:0] e_rdata,
                         input logic e_err);
    logic        e_wr;
    logic [31:0] e_wd;
    e_wr = wr[g];
    e_wd = wd[g];
    drive_reqs();
    @(negedge HCLK);
    for (int i = 0; i <= sa; i++) begin
      chk("addr_htrans", HTRANS, 2'b10);
      chk("addr_hsel", HSEL, 1'b1);
      chk("addr_haddr", HADDR, e_haddr);
      chk("addr_hwrite", HWRITE, e_wr);
      chk("addr_no_ack", {ack1, ack0}, 2'b00);
      HREADY = (i == sa);
      HRDATA = $urandom;
      HRESP  = 1'($urandom);
      if (i == 0) begin
        // Grantee inputs wander after grant; latched values must not follow.
        if (g == 0) begin write0 = 1'($urandom); ionum0 = 4'($urandom); wdata0 = $urandom; end
        else        begin write1 = 1'($urandom); ionum1 = 4'($urandom); wdata1 = $urandom; end
      end
      @(negedge HCLK);
    end
    for (int i = 0; i <= sd; i++) begin
      chk("data_htrans", HTRANS, 2'b00);
      chk("data_hsel", HSEL, 1'b0);
      chk("data_hwdata", HWDATA, e_wd);
      chk("data_no_ack", {ack1, ack0}, 2'b00);
      HREADY = (i == sd);
      HRDATA = (i == sd) ? hrd : $urandom;
      HRESP  = (i == sd) ? hresp_i : 1'($urandom);
      @(negedge HCLK);
    end
    chk("ack_grantee", {ack1, ack0}, (g == 0) ? 2'b01 : 2'b10);
    chk("ack_rdata", rdata, e_rdata);
    chk("ack_err", err, e_err);
    HREADY = 1'b1;
    HRESP  = 1'b0;
    pend[g] = 1'b0;
    drive_reqs();
    @(negedge HCLK);
    chk("ack_one_cycle", {ack1, ack0}, 2'b00);
    chk("idle_htrans", HTRANS, 2'b00);
    lg = g;
    rdata_m = e_rdata;
  endtask

  initial begin
    vt[0] = '{0, 1'b1, 4'h0, 32'h0003FFFF, 32'h00000000, 1'b0, 0, 0, 32'h1F800000, 32'h00000000, 1'b0};
    vt[1] = '{1, 1'b0, 4'h2, 32'h00000000, 32'h000155AA, 1'b0, 0, 0, 32'h1F800008, 32'h000155AA, 1'b0};
    vt[2] = '{0, 1'b1, 4'h5, 32'hDEADBEEF, 32'h11111111, 1'b0, 3, 2, 32'h1F800014, 32'h000155AA, 1'b0};
    vt[3] = '{1, 1'b0, 4'hF, 32'h00000000, 32'h12345678, 1'b1, 0, 0, 32'h1F80003C, 32'h12345678, 1'b1};
    vt[4] = '{0, 1'b0, 4'h1, 32'h0, 32'hA5A5A5A5, 1'b0, 1, 1, 32'h1F800004, 32'hA5A5A5A5, 1'b0};
    vt[5] = '{1, 1'b1, 4'h3, 32'h0, 32'h77777777, 1'b1, 2, 0, 32'h1F80000C, 32'hA5A5A5A5, 1'b1};

    pend[0] = 0; pend[1] = 0;
    wr[0] = 0; wr[1] = 0; ion[0] = 0; ion[1] = 0; wd[0] = 0; wd[1] = 0;
    lg = 1; rdata_m = 32'd0;
    HREADY = 1'b1; HRESP = 1'b0; HRDATA = 32'd0;
    drive_reqs();

    HRESETn = 1'b0;
    repeat (2) @(negedge HCLK);
    chk("rst_htrans", HTRANS, 2'b00);
    chk("rst_hsel", HSEL, 1'b0);
    chk("rst_hwrite", HWRITE, 1'b0);
    chk("rst_haddr", HADDR, 32'd0);
    chk("rst_hwdata", HWDATA, 32'd0);
    chk("rst_acks", {ack1, ack0}, 2'b00);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_err", err, 1'b0);
    chk("hsize", HSIZE, 3'b010);
    chk("hburst", HBURST, 3'b000);
    HRESETn = 1'b1;

    // Directed table, one requester at a time
    for (int k = 0; k < 6; k++) begin
      pend[vt[k].id] = 1'b1;
      wr[vt[k].id]   = vt[k].wr;
      ion[vt[k].id]  = vt[k].ion;
      wd[vt[k].id]   = vt[k].wd;
      run_one(vt[k].id, vt[k].sa, vt[k].sd, vt[k].hrd, vt[k].hresp,
              vt[k].exp_haddr, vt[k].exp_rdata, vt[k].exp_err);
    end

    // Both requesting together, each re-requesting right after its ack; last served was 1
    begin
      int rr_order [4];
      rr_order = '{0, 1, 0, 1};
      pend[0] = 1; wr[0] = 1; ion[0] = 4'h6; wd[0] = 32'h0000A000;
      pend[1] = 1; wr[1] = 1; ion[1] = 4'h8; wd[1] = 32'h0000B000;
      for (int k = 0; k < 4; k++) begin
        int g;
        g = rr_order[k];
        run_one(g, 0, 0, 32'hFFFFFFFF, 1'b0, BASE | {26'd0, ion[g], 2'b00}, rdata_m, 1'b0);
        pend[g] = 1'b1;
        wd[g]   = wd[g] + 32'd1;
      end
      pend[0] = 0; pend[1] = 0;
      drive_reqs();
      @(negedge HCLK);
    end

    // Reset asserted during the data phase
    pend[0] = 1; wr[0] = 1; ion[0] = 4'h7; wd[0] = 32'hCAFEF00D;
    drive_reqs();
    @(negedge HCLK);
    HREADY = 1'b1;
    @(negedge HCLK);
    chk("pre_rst_data_hwdata", HWDATA, 32'hCAFEF00D);
    HREADY = 1'b0;
    #2 HRESETn = 1'b0;
    #1;
    chk("mid_rst_htrans", HTRANS, 2'b00);
    chk("mid_rst_hsel", HSEL, 1'b0);
    chk("mid_rst_acks", {ack1, ack0}, 2'b00);
    chk("mid_rst_hwdata", HWDATA, 32'd0);
    pend[0] = 0;
    drive_reqs();
    HREADY = 1'b1;
    @(negedge HCLK);
    chk("mid_rst_no_ack", {ack1, ack0}, 2'b00);
    HRESETn = 1'b1;
    lg = 1; rdata_m = 32'd0;
    @(negedge HCLK);
    chk("post_rst_no_ack", {ack1, ack0}, 2'b00);
    chk("post_rst_rdata", rdata, 32'd0);
    pend[1] = 1; wr[1] = 0; ion[1] = 4'h9; wd[1] = 32'd0;
    run_one(1, 0, 0, 32'h5A5A0001, 1'b0, 32'h1F800024, 32'h5A5A0001, 1'b0);

    // Randomized traffic against the requester/arbiter model
    for (int it = 0; it < 40; it++) begin
      int          g;
      logic [31:0] hrd;
      logic        hr;
      logic [31:0] e_rd;
      for (int i = 0; i < 2; i++)
        if (!pend[i] && ($urandom_range(0, 1) == 1)) new_tx(i);
      if (!pend[0] && !pend[1]) new_tx(int'($urandom_range(0, 1)));
      g    = (pend[0] && pend[1]) ? (1 - lg) : (pend[0] ? 0 : 1);
      hrd  = $urandom;
      hr   = 1'($urandom);
      e_rd = wr[g] ? rdata_m : hrd;
      run_one(g, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), hrd, hr,
              BASE | {26'd0, ion[g], 2'b00}, e_rd, hr);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
